pipe_stage_reg: RTL and testbench

Generic pipeline stage register with a valid/ready handshake, flush and parametrised payload width. It replaces the fixed-field, stall-driven stage registers (IF/ID … MEM/WB) with one elastic block. Back-pressure propagates through ready instead of per-stage stall lines. An optional skid entry registers the upstream ready and cuts the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Pipeline stage payload bundles and widths for pipe_stage_reg callers.
// Callers pack a bundle into in_data and cast out_data back to the bundle type.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write_en;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
  } idex_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write_en;
    logic        mem_read;
    logic        mem_write;
  } exmem_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [4:0]  reg_write;
    logic        reg_write_en;
    logic [31:0] result;
  } wb_bundle_t;

  localparam int unsigned IFID_DATA_W  = $bits(ifid_bundle_t);
  localparam int unsigned IDEX_DATA_W  = $bits(idex_bundle_t);
  localparam int unsigned EXMEM_DATA_W = $bits(exmem_bundle_t);
  localparam int unsigned WB_DATA_W    = 102;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = WB_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic              main_valid_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_nxt;
  logic [1:0]        occ_nxt;
  logic              in_fire;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_valid_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_nxt;

  // Ready depends only on the skid register; rst/flush gating keeps beats from being lost.
  assign in_ready = ~skid_valid & ~rst & ~flush;

  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (skid_valid) begin
      if (out_ready) begin
        main_data_nxt  = skid_data;
        skid_valid_nxt = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid && !out_ready) begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = in_data;
      end else begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = in_data;
      end
    end else if (out_ready) begin
      main_valid_nxt = 1'b0;
    end
    occ_nxt = 2'(main_valid_nxt) + 2'(skid_valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_valid <= 1'b0;
      skid_data  <= RST_VAL;
    end else begin
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
    end
  end
`else
  assign in_ready = (~main_valid | out_ready) & ~rst & ~flush;

  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    if (in_fire) begin
      main_valid_nxt = 1'b1;
      main_data_nxt  = in_data;
    end else if (out_ready) begin
      main_valid_nxt = 1'b0;
    end
    occ_nxt = {1'b0, main_valid_nxt};
  end
`endif

  // Data only moves on a load, so out_data holds while the stage drains or stalls.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_data  <= RST_VAL;
      occupancy  <= 2'd0;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      occupancy  <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks for pipe_stage_reg against a scoreboard queue.
// Expectations follow PIPE_STAGE_SKID_EN when the bench is built with it.
module tb_pipe_stage_reg;

  localparam int unsigned W = 102;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned OCC_FULL = 2;
  localparam bit          SKID     = 1'b1;
`else
  localparam int unsigned OCC_FULL = 1;
  localparam bit          SKID     = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sb[$];
  logic         in_fire;
  logic         out_fire;
  logic         stalled;
  logic [W-1:0] held;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(32'h55); out_ready = 1'b0;

    // Reset held for two cycles with a beat on offer.
    #1;
    check("rst_in_ready_c0", 128'(in_ready), 128'(0));
    step();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_in_ready_c1", 128'(in_ready), 128'(0));
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_out_valid", 128'(out_valid), 128'(0));

    // Back-to-back streaming.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      #1;
      check("stream_in_ready", 128'(in_ready), 128'(1));
      step();
      check("stream_valid", 128'(out_valid), 128'(1));
      check("stream_data", 128'(out_data), 128'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", 128'(out_valid), 128'(0));
    check("stream_data_hold", 128'(out_data), 128'(8));

    // Stall with 0xB waiting.
    in_valid = 1'b1; in_data = W'(32'hA);
    step();
    check("stall_a_loaded", 128'(out_data), 128'(32'hA));
    in_data = W'(32'hB); out_ready = 1'b0;
    #1;
    check("stall_in_ready_0", 128'(in_ready), 128'(SKID));
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_data", 128'(out_data), 128'(32'hA));
      check("stall_occ", 128'(occupancy), 128'(OCC_FULL));
      check("stall_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1; in_valid = !SKID;
    #1;
    check("release_in_ready", 128'(in_ready), 128'(!SKID));
    step();
    in_valid = 1'b0;
    check("release_b_valid", 128'(out_valid), 128'(1));
    check("release_b_data", 128'(out_data), 128'(32'hB));
    check("release_b_occ", 128'(occupancy), 128'(1));
    step();
    check("release_empty", 128'(out_valid), 128'(0));

    // Fill, then flush with 0xC on offer.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'hD);
    step();
    in_data = W'(32'hE);
    step();
    check("fill_occ", 128'(occupancy), 128'(OCC_FULL));
    flush = 1'b1; out_ready = 1'b1; in_data = W'(32'hC);
    #1;
    check("flush_in_ready", 128'(in_ready), 128'(0));
    step();
    flush = 1'b0;
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_occ", 128'(occupancy), 128'(0));
    check("flush_data", 128'(out_data), 128'(0));
    #1;
    check("flush_reoffer_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("flush_c_valid", 128'(out_valid), 128'(1));
    check("flush_c_data", 128'(out_data), 128'(32'hC));
    step();
    check("flush_drained", 128'(out_valid), 128'(0));

    // Random valid/ready against the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {6'($urandom), $urandom, $urandom, $urandom};
      #1;
      if (SKID) check("rnd_in_ready", 128'(in_ready), 128'(sb.size() < 2));
      else      check("rnd_in_ready", 128'(in_ready), 128'((sb.size() == 0) || out_ready));
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      stalled  = out_valid & ~out_ready;
      held     = out_data;
      if (out_fire && sb.size() != 0) void'(sb.pop_front());
      if (in_fire) sb.push_back(in_data);
      step();
      check("rnd_valid", 128'(out_valid), 128'(sb.size() != 0));
      check("rnd_occ", 128'(occupancy), 128'(sb.size()));
      if (out_valid && sb.size() != 0) check("rnd_order", 128'(out_data), 128'(sb[0]));
      if (stalled) check("rnd_hold", 128'(out_data), 128'(held));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
